spike_dispatcher: RTL

//  Transmit end of the spike source-address bus that the MAC units listen on.
//  At each timestep start it snapshots the layer's neuron spike vector.
//  It serialises every set bit onto source_address as BASE_ADDR+index, then pulses clear_mac.
//  The clear_mac pulse makes the listening MACs latch their accumulated spikes.

---
 rtl/snn_bus_pkg.sv | 35 +++
 rtl/spike_prio_enc.sv | 28 ++
 rtl/spike_dispatcher.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/snn_bus_pkg.sv
// Purpose : shared definitions for the spike source-address bus (dispatcher and MAC side).
// Latency : n/a (package only).
// Backpr. : n/a.
// Contents: bus width / idle address defaults, dispatcher state encoding, clog2 sizing helper.
package snn_bus_pkg;

  localparam int                    SNN_ADDR_W    = 12;
  localparam logic [SNN_ADDR_W-1:0] SNN_IDLE_ADDR = 12'hFFF;

  // Dispatcher state encoding, kept here so bus-side debug logic decodes it identically.
  localparam logic [2:0] DISP_IDLE  = 3'd0;
  localparam logic [2:0] DISP_SCAN  = 3'd1;
  localparam logic [2:0] DISP_EMIT  = 3'd2;
  localparam logic [2:0] DISP_GAP   = 3'd3;
  localparam logic [2:0] DISP_CLEAR = 3'd4;
  localparam logic [2:0] DISP_DONE  = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE  = DISP_IDLE,
    ST_SCAN  = DISP_SCAN,
    ST_EMIT  = DISP_EMIT,
    ST_GAP   = DISP_GAP,
    ST_CLEAR = DISP_CLEAR,
    ST_DONE  = DISP_DONE
  } disp_state_t;

  // Bits needed to index n items; never less than 1 so vectors stay legal.
  function automatic int snn_clog2(input int n);
    int r;
    r = 1;
    while ((1 << r) < n) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/spike_prio_enc.sv
// Purpose : combinational lowest-set-bit encoder over the spike shadow vector.
// Latency : 0 cycles (pure combinational).
// Backpr. : none; output follows vec.
// Ports   : vec[NUM_NEURONS] in; idx (index of lowest set bit, 0 when none) out; any (vec != 0) out.
module spike_prio_enc
  import snn_bus_pkg::*;
#(
  parameter int NUM_NEURONS = 30,
  parameter int IDX_W       = snn_clog2(NUM_NEURONS)
) (
  input  logic [NUM_NEURONS-1:0] vec,
  output logic [IDX_W-1:0]       idx,
  output logic                   any
);

  // Walk from the top down so the last hit, i.e. the lowest index, wins.
  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int i = NUM_NEURONS - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx = IDX_W'(i);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/spike_dispatcher.sv
// Purpose : snapshot a layer's spike vector and serialise each set bit as BASE_ADDR+idx onto the MAC bus, then strobe clear_mac.
// Latency : start at T -> first addr_valid at T+2; 3 cycles per spike with GAP_CYCLES=1 and addr_ready high.
// Backpr. : addr_ready low holds the address and addr_valid stable indefinitely (no timeout).
// Ports   : clock, reset (async, active-high); timestep_start, spikes_in in; source_address, addr_valid out;
//           addr_ready in; clear_mac, busy, done, overrun (sticky) out.
// Config  : define SPIKE_DISPATCH_STATS_EN to add the spike_count output (spikes accepted this timestep).
module spike_dispatcher
  import snn_bus_pkg::*;
#(
  parameter int              NUM_NEURONS  = 30,
  parameter int              ADDR_W       = SNN_ADDR_W,
  parameter int              BASE_ADDR    = 0,
  parameter logic [ADDR_W-1:0] IDLE_ADDR  = SNN_IDLE_ADDR,
  parameter int              GAP_CYCLES   = 1,
  parameter int              CLEAR_CYCLES = 2
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   timestep_start,
  input  logic [NUM_NEURONS-1:0] spikes_in,
  output logic [ADDR_W-1:0]      source_address,
  output logic                   addr_valid,
  input  logic                   addr_ready,
  output logic                   clear_mac,
  output logic                   busy,
  output logic                   done,
  output logic                   overrun
`ifdef SPIKE_DISPATCH_STATS_EN
  ,
  output logic [$clog2(NUM_NEURONS+1)-1:0] spike_count
`endif
);

  localparam int IDX_W   = snn_clog2(NUM_NEURONS);
  localparam int CNT_MAX = (GAP_CYCLES > CLEAR_CYCLES) ? GAP_CYCLES : CLEAR_CYCLES;
  localparam int CNT_W   = snn_clog2(CNT_MAX + 1);
  localparam logic [ADDR_W-1:0] BASE_V = ADDR_W'(BASE_ADDR);

  // The idle code must never collide with a real neuron address.
  generate
    if (BASE_ADDR + NUM_NEURONS - 1 >= int'(IDLE_ADDR)) begin : g_bad_addr_cfg
      $error("spike_dispatcher: BASE_ADDR+NUM_NEURONS-1 must be below IDLE_ADDR");
    end
  endgenerate

  disp_state_t            r_state, w_state_nxt;
  logic [NUM_NEURONS-1:0] r_shadow, w_shadow_nxt;
  logic [CNT_W-1:0]       r_cnt, w_cnt_nxt;
  logic [ADDR_W-1:0]      r_addr, w_addr_nxt;
  logic                   r_addr_valid, r_clear_mac, r_busy, r_done, r_overrun;
  logic [IDX_W-1:0]       w_idx;
  logic                   w_any;
  logic                   w_hs;

  spike_prio_enc #(
    .NUM_NEURONS (NUM_NEURONS),
    .IDX_W       (IDX_W)
  ) u_prio_enc (
    .vec (r_shadow),
    .idx (w_idx),
    .any (w_any)
  );

  assign w_hs = r_addr_valid && addr_ready;

  always_comb begin
    w_state_nxt  = r_state;
    w_shadow_nxt = r_shadow;
    w_cnt_nxt    = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (timestep_start) begin
          w_shadow_nxt = spikes_in;
          w_state_nxt  = ST_SCAN;
        end
      end
      ST_SCAN: begin
        w_cnt_nxt   = '0;
        w_state_nxt = w_any ? ST_EMIT : ST_CLEAR;
      end
      ST_EMIT: begin
        if (w_hs) begin
          w_shadow_nxt[w_idx] = 1'b0;
          w_cnt_nxt           = '0;
          w_state_nxt         = ST_GAP;
        end
      end
      ST_GAP: begin
        if (r_cnt == CNT_W'(GAP_CYCLES - 1)) w_state_nxt = ST_SCAN;
        else                                  w_cnt_nxt   = r_cnt + 1'b1;
      end
      ST_CLEAR: begin
        if (r_cnt == CNT_W'(CLEAR_CYCLES - 1)) w_state_nxt = ST_DONE;
        else                                    w_cnt_nxt   = r_cnt + 1'b1;
      end
      ST_DONE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
    // Address is taken from the live encoder; the shadow does not change while in EMIT, so it stays stable.
    w_addr_nxt = (w_state_nxt == ST_EMIT) ? (BASE_V + ADDR_W'(w_idx)) : IDLE_ADDR;
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_shadow     <= '0;
      r_cnt        <= '0;
      r_addr       <= IDLE_ADDR;
      r_addr_valid <= 1'b0;
      r_clear_mac  <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_shadow     <= w_shadow_nxt;
      r_cnt        <= w_cnt_nxt;
      r_addr       <= w_addr_nxt;
      r_addr_valid <= (w_state_nxt == ST_EMIT);
      r_clear_mac  <= (w_state_nxt == ST_CLEAR);
      r_busy       <= (w_state_nxt != ST_IDLE);
      r_done       <= (w_state_nxt == ST_DONE);
      if (timestep_start && (r_state != ST_IDLE)) r_overrun <= 1'b1;
    end
  end

  assign source_address = r_addr;
  assign addr_valid     = r_addr_valid;
  assign clear_mac      = r_clear_mac;
  assign busy           = r_busy;
  assign done           = r_done;
  assign overrun        = r_overrun;

`ifdef SPIKE_DISPATCH_STATS_EN
  logic [$clog2(NUM_NEURONS+1)-1:0] r_spike_count;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_spike_count <= '0;
    end else if ((r_state == ST_IDLE) && timestep_start) begin
      r_spike_count <= '0;
    end else if (w_hs) begin
      r_spike_count <= r_spike_count + 1'b1;
    end
  end

  assign spike_count = r_spike_count;
`endif

endmodule
